// File: rtl/hvac_sequencer_if.sv
// Request/actuator bundle between the thermostat FSM (master) and hvac_sequencer (slave).
interface hvac_sequencer_if;
  logic req_heat;
  logic req_cool;
  logic heater_en;
  logic compressor_en;
  logic fan_en;
  logic busy;
  logic conflict;

  modport master (
    output req_heat, req_cool,
    input  heater_en, compressor_en, fan_en, busy, conflict
  );

  modport slave (
    input  req_heat, req_cool,
    output heater_en, compressor_en, fan_en, busy, conflict
  );
endinterface

// File: rtl/hvac_sequencer.sv
// Turns thermostat heat/cool requests into a fan pre-run / min-on / fan post-run / lockout
// actuator sequence with registered, state-decoded outputs.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_OFF      | idle, all actuators off, waiting for a clean request
// S_FAN_PRE  | fan alone before heater/compressor start
// S_HEAT_RUN | heater + fan, held at least MIN_ON_CYC cycles
// S_COOL_RUN | compressor + fan, held at least MIN_ON_CYC cycles
// S_FAN_POST | fan alone after heater/compressor stop
// S_LOCKOUT  | everything off, minimum off-time before next start
module hvac_sequencer #(
  parameter int FAN_PRE_CYC  = 2,
  parameter int MIN_ON_CYC   = 8,
  parameter int FAN_POST_CYC = 3,
  parameter int MIN_OFF_CYC  = 6,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  hvac_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF,
    S_FAN_PRE,
    S_HEAT_RUN,
    S_COOL_RUN,
    S_FAN_POST,
    S_LOCKOUT
  } state_t;

  localparam logic MODE_HEAT = 1'b0;
  localparam logic MODE_COOL = 1'b1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(FAN_PRE_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(FAN_POST_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             heater_en_q, heater_en_d;
  logic             compressor_en_q, compressor_en_d;
  logic             fan_en_q, fan_en_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;

  // A simultaneous heat+cool request is treated as no request at all.
  logic rh, rc, mode_req;
  assign rh       = bus.req_heat & ~bus.req_cool;
  assign rc       = bus.req_cool & ~bus.req_heat;
  assign mode_req = (mode_q == MODE_COOL) ? rc : rh;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;

    case (state_q)
      S_OFF: begin
        if (rh) begin
          state_d = S_FAN_PRE;
          mode_d  = MODE_HEAT;
        end else if (rc) begin
          state_d = S_FAN_PRE;
          mode_d  = MODE_COOL;
        end
      end
      S_FAN_PRE: begin
        if (!mode_req)
          state_d = S_FAN_POST;
        else if (cnt_q == PRE_LAST)
          state_d = (mode_q == MODE_COOL) ? S_COOL_RUN : S_HEAT_RUN;
      end
      S_HEAT_RUN: if (!rh && cnt_q == ON_LAST) state_d = S_FAN_POST;
      S_COOL_RUN: if (!rc && cnt_q == ON_LAST) state_d = S_FAN_POST;
      S_FAN_POST: if (cnt_q == POST_LAST)      state_d = S_LOCKOUT;
      S_LOCKOUT:  if (cnt_q == OFF_LAST)       state_d = S_OFF;
      default:    state_d = S_LOCKOUT;
    endcase

    // Run states saturate so a long request never wraps the counter.
    if (state_d != state_q)
      cnt_d = '0;
    else if ((state_q == S_HEAT_RUN || state_q == S_COOL_RUN) && cnt_q == ON_LAST)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);

    heater_en_d     = (state_d == S_HEAT_RUN);
    compressor_en_d = (state_d == S_COOL_RUN);
    fan_en_d        = (state_d == S_FAN_PRE) || (state_d == S_HEAT_RUN) ||
                      (state_d == S_COOL_RUN) || (state_d == S_FAN_POST);
    busy_d          = (state_d != S_OFF);
    conflict_d      = bus.req_heat & bus.req_cool;
  end

  // Reset lands in LOCKOUT so the compressor gets its full off-time across resets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_LOCKOUT;
      cnt_q           <= '0;
      mode_q          <= MODE_HEAT;
      heater_en_q     <= 1'b0;
      compressor_en_q <= 1'b0;
      fan_en_q        <= 1'b0;
      busy_q          <= 1'b1;
      conflict_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mode_q          <= mode_d;
      heater_en_q     <= heater_en_d;
      compressor_en_q <= compressor_en_d;
      fan_en_q        <= fan_en_d;
      busy_q          <= busy_d;
      conflict_q      <= conflict_d;
    end
  end

  assign bus.heater_en     = heater_en_q;
  assign bus.compressor_en = compressor_en_q;
  assign bus.fan_en        = fan_en_q;
  assign bus.busy          = busy_q;
  assign bus.conflict      = conflict_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer with default timing parameters; edge counts are
// taken from reset release, outputs sampled 1 time unit after each rising edge.
module tb_hvac_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hvac_sequencer_if bus();

  hvac_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic h, input logic c);
    bus.req_heat = h;
    bus.req_cool = c;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic [4:0] got;
    bus.req_heat = 1'b0;
    bus.req_cool = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy, bus.conflict};
    checks++;
    if (got !== 5'b00010) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", got, 5'b00010);
    end
    tick();
    tick();
    got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy, bus.conflict};
    checks++;
    if (got !== 5'b00010) begin
      errors++;
      $display("FAIL reset_held got=%b exp=%b", got, 5'b00010);
    end
  endtask

  task automatic test_heat_start;
    logic [3:0] got, exp;
    do_reset(1'b1, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      tick();
      got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
      exp = {n >= 9, 1'b0, n >= 7, n != 6};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL heat_start n=%0d got=%b exp=%b", n, got, exp);
      end
    end
    bus.req_heat = 1'b0;
  endtask

  task automatic test_cool_drop;
    logic [3:0] got, exp;
    do_reset(1'b0, 1'b1);
    for (int n = 1; n <= 27; n++) begin
      tick();
      got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
      exp = {1'b0, (n >= 9 && n <= 16), (n >= 7 && n <= 19), (n != 6 && n < 26)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cool_drop n=%0d got=%b exp=%b", n, got, exp);
      end
      if (n == 11) bus.req_cool = 1'b0;
    end
  endtask

  task automatic test_pre_abort;
    logic [3:0] got, exp;
    do_reset(1'b1, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
      exp = {1'b0, 1'b0, (n >= 7 && n <= 11), (n != 6 && n < 18)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pre_abort n=%0d got=%b exp=%b", n, got, exp);
      end
      if (n == 8) bus.req_heat = 1'b0;
    end
  endtask

  task automatic test_heat_to_cool;
    logic [3:0] got, exp;
    do_reset(1'b1, 1'b0);
    for (int n = 1; n <= 44; n++) begin
      tick();
      got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
      exp = {(n >= 9 && n <= 28), n >= 41, ((n >= 7 && n <= 31) || n >= 39),
             (n != 6 && n != 38)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL heat_to_cool n=%0d got=%b exp=%b", n, got, exp);
      end
      checks++;
      if ((bus.heater_en & bus.compressor_en) !== 1'b0) begin
        errors++;
        $display("FAIL both_actuators n=%0d got=%b exp=0", n,
                 bus.heater_en & bus.compressor_en);
      end
      if (n == 28) begin
        bus.req_heat = 1'b0;
        bus.req_cool = 1'b1;
      end
    end
    bus.req_cool = 1'b0;
  endtask

  task automatic test_conflict;
    logic [3:0] got, exp;
    logic       exp_c;
    do_reset(1'b0, 1'b0);
    for (int n = 1; n <= 22; n++) begin
      tick();
      got   = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
      exp   = {1'b0, (n >= 12 && n <= 20), n >= 10, !(n >= 6 && n <= 9)};
      exp_c = (n >= 7 && n <= 9) || n >= 21;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL conflict_outputs n=%0d got=%b exp=%b", n, got, exp);
      end
      checks++;
      if (bus.conflict !== exp_c) begin
        errors++;
        $display("FAIL conflict_flag n=%0d got=%b exp=%b", n, bus.conflict, exp_c);
      end
      if (n == 6) begin
        bus.req_heat = 1'b1;
        bus.req_cool = 1'b1;
      end
      if (n == 9)  bus.req_heat = 1'b0;
      if (n == 20) bus.req_heat = 1'b1;
    end
    bus.req_heat = 1'b0;
    bus.req_cool = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [3:0] got, exp;
    do_reset(1'b0, 1'b1);
    for (int n = 1; n <= 12; n++) tick();
    got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
    checks++;
    if (got !== 4'b0111) begin
      errors++;
      $display("FAIL mid_run_pre got=%b exp=%b", got, 4'b0111);
    end
    #3;
    reset = 1'b0;
    #1;
    got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL mid_run_async got=%b exp=%b", got, 4'b0001);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      got = {bus.heater_en, bus.compressor_en, bus.fan_en, bus.busy};
      exp = {1'b0, 1'b0, n >= 7, n != 6};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_run_lockout n=%0d got=%b exp=%b", n, got, exp);
      end
    end
    bus.req_cool = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.req_heat = 1'b0;
    bus.req_cool = 1'b0;
    test_reset();
    test_heat_start();
    test_cool_drop();
    test_pre_abort();
    test_heat_to_cool();
    test_conflict();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
